polaris_dbus_bridge: RTL
========================

// Module: polaris_dbus_bridge
// PURPOSE
//  Sits directly downstream of the PolarisCPU D-master port. It turns each sized 64-bit CPU data
//  access (byte, half, word or dword, any alignment) into a sequence of 16-bit Wishbone-classic
//  beats to external memory. It assembles and sign/zero-extends read data, then returns a single
//  cdack_o to the CPU. It owns no memory.
// PARAMETERS
//  AW  24  byte-address width on memory side; wadr_o carries bits [AW-1:1]; cdadr_i[63:AW] ignored
// PORTS
//  clk_i       in   1   system clock; all state changes on rising edge
//  reset_i     in   1   synchronous, active-high reset
//  cdadr_i     in   64  CPU byte address (dadr_o)
//  cddat_i     in   64  CPU store data, right-justified (ddat_o)
//  cdsiz_i     in   2   00=byte 01=half 10=word 11=dword (dsiz_o)
//  cdsigned_i  in   1   1=sign-extend load result (dsigned_o)
//  cdwe_i      in   1   1=store (dwe_o)
//  cdcyc_i     in   1   CPU cycle (dcyc_o)
//  cdstb_i     in   1   CPU strobe (dstb_o)
//  cdack_o     out  1   one-cycle completion pulse to CPU (dack_i)
//  cddat_o     out  64  extended load data to CPU (ddat_i); valid only while cdack_o=1 on a load
//  wadr_o      out  AW-1  memory halfword address
//  wdat_o      out  16  store data; even byte on [7:0], odd byte on [15:8]
//  wdat_i      in   16  load data, same lane map
//  wsel_o      out  2   byte lane selects: [0]=even byte, [1]=odd byte
//  wwe_o       out  1   memory write enable
//  wcyc_o      out  1   memory cycle
//  wstb_o      out  1   memory strobe
//  wack_i      in   1   memory beat acknowledge
// BEHAVIOUR
//  Reset: state=IDLE. cdack_o, wcyc_o, wstb_o, wwe_o = 0. wsel_o=00. cddat_o, wdat_o, wadr_o = 0.
//    Assembly buffer and counters are cleared. Reset mid-transfer abandons the beat at once.
//    No ack is ever issued for an abandoned access.
//  FSM IDLE -> BEAT -> DONE -> IDLE.
//  IDLE: on cdcyc_i & cdstb_i, latch address, data, size, signed and we.
//    rem = 1<<cdsiz_i bytes; off = 0. Go to BEAT.
//  BEAT: wcyc_o = wstb_o = 1; wwe_o = latched we; wadr_o = cur[AW-1:1].
//    Beat width, chosen each beat:
//      cur[0]=1         -> 1 byte, wsel_o=10
//      cur[0]=0, rem>=2 -> 2 bytes, wsel_o=11
//      cur[0]=0, rem=1  -> 1 byte, wsel_o=01
//    Store bytes come from data byte index off, placed on the selected lanes.
//    Unselected lanes of wdat_o = 0.
//    On wack_i: loads write the selected wdat_i bytes into buffer bytes off...
//      cur += n (mod 2^AW); off += n; rem -= n.
//      If rem becomes 0 -> DONE; otherwise stay in BEAT with strobe held (no idle cycle).
//  Beat counts: aligned access takes 1<<siz /2 beats (byte=1); misaligned adds exactly one beat.
//    Example: half at odd address = 2 beats; dword at odd address = 5 beats.
//  DONE: cdack_o=1 for exactly one cycle, wcyc_o=0.
//    Load: cddat_o = buffer truncated to 8<<siz bits, sign-extended if signed, else zero-extended.
//    Store: cddat_o = 0. Then go to IDLE.
//  Latency: with zero-wait memory, cdack_o rises (1 + beats) cycles after request.
//    Each memory wait state adds one cycle.
//  The CPU must drop cdstb_i in the cycle after cdack_o. A request still present in IDLE then
//    starts a new access; this is master error, not guarded.
//  If cdcyc_i drops during BEAT: wcyc_o/wstb_o are gated low in that same cycle.
//    A wack_i in that cycle is ignored; IDLE next edge; no cdack_o.
//  Address wrap at 2^AW is silent; no bus error signalling exists in this revision.
// STRUCTURE
//  polaris_dbus_pkg holds:
//    size codes SIZ_B/SIZ_H/SIZ_W/SIZ_D
//    FSM encodings ST_IDLE/ST_BEAT/ST_DONE
//    lane-select constants SEL_LO/SEL_HI/SEL_BOTH
//  One sub-module, polaris_load_extend: combinational (buf64, siz, signed) -> 64-bit result.
//    It is shared later with the I-side path.
//  Bridge body: FSM, byte counters, lane muxes, assembly buffer.
// TESTING
//  1 LHU at 0x..DEADB123, memory returns 16'hFC00@0x91 then 16'h00FF@0x92:
//    2 beats, wsel 10 then 01; cddat_o=64'h0000_0000_0000_FFFC; one cdack_o.
//  2 LB at 0x10000, wdat_i=16'hFFFC, cdsigned_i=1:
//    1 beat, wsel 01; cddat_o=64'hFFFF_FFFF_FFFF_FFFC.
//  3 SD 64'h0000_0000_0000_FFFC at 0x10008:
//    4 beats at wadr 0x8004..0x8007, wsel 11, wdat FFFC,0000,0000,0000.
//    wwe_o=1 throughout; cdack_o after 5 cycles with zero-wait memory.
//  4 SW at 0x3 (odd) with data 32'h11223344:
//    beats wsel 10/11/01, wdat 4400, 2233, 0011.
//    Repeat with wack_i delayed 2 cycles per beat: cdack_o arrives 6 cycles later.
//  5 reset_i asserted during beat 2 of an SD: next cycle wcyc_o=0, cdack_o never pulses.
//    A fresh LB then completes normally.
//  6 cdcyc_i dropped mid-BEAT with wack_i=1 same cycle: wcyc_o=0 that cycle; no cdack_o.
//    FSM in IDLE next cycle.

Source files
------------

// File: rtl/polaris_dbus_pkg.sv
// Shared types and constants for the PolarisCPU data-bus bridge.
// Size codes, FSM encoding, lane selects and the latched request bundle.
package polaris_dbus_pkg;

    localparam logic [1:0] SIZ_B = 2'b00;
    localparam logic [1:0] SIZ_H = 2'b01;
    localparam logic [1:0] SIZ_W = 2'b10;
    localparam logic [1:0] SIZ_D = 2'b11;

    localparam logic [1:0] SEL_LO   = 2'b01;
    localparam logic [1:0] SEL_HI   = 2'b10;
    localparam logic [1:0] SEL_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [63:0] dat;
        logic [1:0]  siz;
        logic        sgn;
        logic        we;
    } req_t;

endpackage

// File: rtl/polaris_load_extend.sv
// Truncates an assembled 64-bit load buffer to the access size and
// sign- or zero-extends it; purely combinational.
module polaris_load_extend
    import polaris_dbus_pkg::*;
(
    input  logic [63:0] buf64,
    input  logic [1:0]  siz,
    input  logic        sgn,
    output logic [63:0] res
);

    always_comb begin
        res = buf64;
        unique case (siz)
            SIZ_B: res = {{56{sgn & buf64[7]}}, buf64[7:0]};
            SIZ_H: res = {{48{sgn & buf64[15]}}, buf64[15:0]};
            SIZ_W: res = {{32{sgn & buf64[31]}}, buf64[31:0]};
            SIZ_D: res = buf64;
        endcase
    end

endmodule

// File: rtl/polaris_dbus_bridge.sv
// Splits sized 64-bit CPU data accesses into 16-bit Wishbone-classic beats
// and returns one ack with extended load data.
module polaris_dbus_bridge
    import polaris_dbus_pkg::*;
#(
    parameter int AW = 24
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [63:0]   cdadr_i,
    input  logic [63:0]   cddat_i,
    input  logic [1:0]    cdsiz_i,
    input  logic          cdsigned_i,
    input  logic          cdwe_i,
    input  logic          cdcyc_i,
    input  logic          cdstb_i,
    output logic          cdack_o,
    output logic [63:0]   cddat_o,
    output logic [AW-2:0] wadr_o,
    output logic [15:0]   wdat_o,
    input  logic [15:0]   wdat_i,
    output logic [1:0]    wsel_o,
    output logic          wwe_o,
    output logic          wcyc_o,
    output logic          wstb_o,
    input  logic          wack_i
);

    state_e        state_q, state_d;
    req_t          req_q;
    logic [AW-1:0] cur_q;
    logic [3:0]    off_q, rem_q;
    logic [63:0]   buf_q;
    logic [63:0]   ext;
    logic          req, odd, wide, fire;
    logic [3:0]    n;
    logic [2:0]    o0, o1;
    logic [7:0]    b0, b1;
    logic          unused_adr;

    assign unused_adr = ^cdadr_i[63:AW];

    assign req  = cdcyc_i & cdstb_i;
    assign odd  = cur_q[0];
    assign wide = ~odd & (rem_q >= 4'd2);
    assign n    = wide ? 4'd2 : 4'd1;
    assign o0   = off_q[2:0];
    assign o1   = o0 + 3'd1;
    assign b0   = req_q.dat[{o0, 3'b000} +: 8];
    assign b1   = req_q.dat[{o1, 3'b000} +: 8];
    // A dropped CPU cycle kills the beat, so its ack must not advance.
    assign fire = (state_q == ST_BEAT) & cdcyc_i & wack_i;

    polaris_load_extend u_ext (
        .buf64 (buf_q),
        .siz   (req_q.siz),
        .sgn   (req_q.sgn),
        .res   (ext)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cdack_o = 1'b0;
        cddat_o = '0;
        wcyc_o  = 1'b0;
        wstb_o  = 1'b0;
        wwe_o   = 1'b0;
        wsel_o  = 2'b00;
        wadr_o  = '0;
        wdat_o  = '0;
        unique case (state_q)
            ST_IDLE: if (req) state_d = ST_BEAT;
            ST_BEAT: begin
                if (!cdcyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    wcyc_o = 1'b1;
                    wstb_o = 1'b1;
                    wwe_o  = req_q.we;
                    wadr_o = cur_q[AW-1:1];
                    unique case (1'b1)
                        odd: begin
                            wsel_o = SEL_HI;
                            wdat_o = {b0, 8'h00};
                        end
                        wide: begin
                            wsel_o = SEL_BOTH;
                            wdat_o = {b1, b0};
                        end
                        default: begin
                            wsel_o = SEL_LO;
                            wdat_o = {8'h00, b0};
                        end
                    endcase
                    if (wack_i && rem_q == n) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cdack_o = 1'b1;
                cddat_o = req_q.we ? '0 : ext;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            req_q <= '0;
            cur_q <= '0;
            off_q <= '0;
            rem_q <= '0;
            buf_q <= '0;
        end else if (state_q == ST_IDLE && req) begin
            req_q.dat <= cddat_i;
            req_q.siz <= cdsiz_i;
            req_q.sgn <= cdsigned_i;
            req_q.we  <= cdwe_i;
            cur_q     <= cdadr_i[AW-1:0];
            off_q     <= '0;
            rem_q     <= 4'd1 << cdsiz_i;
            buf_q     <= '0;
        end else if (fire) begin
            unique case (1'b1)
                odd: buf_q[{o0, 3'b000} +: 8] <= wdat_i[15:8];
                wide: begin
                    buf_q[{o0, 3'b000} +: 8] <= wdat_i[7:0];
                    buf_q[{o1, 3'b000} +: 8] <= wdat_i[15:8];
                end
                default: buf_q[{o0, 3'b000} +: 8] <= wdat_i[7:0];
            endcase
            cur_q <= cur_q + AW'(n);
            off_q <= off_q + n;
            rem_q <= rem_q - n;
        end
    end

endmodule
